// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: command codes,
// FSM state encoding and command-word field positions.
package program_loader_pkg;

    localparam int unsigned TMR_W   = 4;
    localparam int unsigned LEN_W   = 14;
    localparam int unsigned WCNT_W  = 16;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned CMD_MSB = 15;
    localparam int unsigned CMD_LSB = 14;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_SETADDR = 2'b01,
        CMD_DATA    = 2'b10,
        CMD_START   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_FMRST   = 3'd0,
        S_IDLE    = 3'd1,
        S_ADDR_HI = 3'd2,
        S_ADDR_LO = 3'd3,
        S_DATA    = 3'd4,
        S_RELEASE = 3'd5,
        S_RUN     = 3'd6
    } state_e;

    // States in which the loader takes words from the command stream.
    function automatic logic accepts_words(input state_e s);
        return (s == S_IDLE) || (s == S_ADDR_HI) || (s == S_ADDR_LO) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/program_loader_timer.sv
// Reloadable down-counter; done_o is registered and high while the count sits at zero.
module loader_cycle_timer #(
    parameter int unsigned W         = 4,
    parameter int unsigned RESET_VAL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= W'(RESET_VAL);
            done_q <= (RESET_VAL == 0);
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == '0);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time initiator for the instruction-memory load port: decodes a valid/ready
// command stream into memory writes, then releases the processor from reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned FM_RST_CYCLES   = 2,
    parameter int unsigned PROC_RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rst_fm,
    output logic              write_enable_fm,
    output logic [ADDR_W-1:0] write_addr_fm,
    output logic [DATA_W-1:0] write_data_fm,
    output logic              proc_reset,
    output logic              done,
    output logic [WCNT_W-1:0] words_written,
    output logic              addr_wrap
);

    localparam logic [TMR_W-1:0] PROC_LOAD = TMR_W'(PROC_RST_CYCLES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HALF_W-1:0]   hi_q, hi_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [WCNT_W-1:0]   words_q, words_d;
    logic                we_q, we_d;
    logic                wrap_q, wrap_d;
    logic                in_ready_q, in_ready_d;
    logic                rst_fm_q, rst_fm_d;
    logic                proc_reset_q, proc_reset_d;
    logic                done_q, done_d;
    logic                xfer;
    cmd_e                cmd;
    logic [LEN_W-1:0]    len;
    logic                tmr_load;
    logic                tmr_done;

    // One timer covers both the memory-reset hold and the processor-reset hold.
    loader_cycle_timer #(
        .W         (TMR_W),
        .RESET_VAL (FM_RST_CYCLES - 1)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (PROC_LOAD),
        .done_o     (tmr_done)
    );

    assign xfer = in_valid && in_ready_q;
    assign cmd  = cmd_e'(in_data[CMD_MSB:CMD_LSB]);
    assign len  = in_data[LEN_W-1:0];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        words_d  = words_q;
        wrap_d   = wrap_q;
        we_d     = 1'b0;
        tmr_load = 1'b0;

        // The address advances on the cycle after each strobe.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
            if (&addr_q) begin
                wrap_d = 1'b1;
            end
        end

        case (state_q)
            S_FMRST: begin
                if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (xfer) begin
                    case (cmd)
                        CMD_SETADDR: state_d = S_ADDR_HI;
                        CMD_DATA: begin
                            if (len != '0) begin
                                cnt_d   = len;
                                state_d = S_DATA;
                            end
                        end
                        CMD_START: begin
                            tmr_load = 1'b1;
                            state_d  = S_RELEASE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ADDR_HI: begin
                if (xfer) begin
                    hi_d    = in_data[HALF_W-1:0];
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (xfer) begin
                    addr_d  = ADDR_W'({hi_q, in_data[HALF_W-1:0]});
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d   = 1'b1;
                    data_d = in_data;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (words_q != '1) begin
                        words_d = words_q + WCNT_W'(1);
                    end
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RELEASE: begin
                if (tmr_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: state_d = S_RUN;
            default: state_d = S_FMRST;
        endcase

        in_ready_d   = accepts_words(state_d);
        rst_fm_d     = (state_d == S_FMRST);
        proc_reset_d = (state_d != S_RUN);
        done_d       = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FMRST;
            addr_q       <= '0;
            hi_q         <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            words_q      <= '0;
            we_q         <= 1'b0;
            wrap_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            rst_fm_q     <= 1'b1;
            proc_reset_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            words_q      <= words_d;
            we_q         <= we_d;
            wrap_q       <= wrap_d;
            in_ready_q   <= in_ready_d;
            rst_fm_q     <= rst_fm_d;
            proc_reset_q <= proc_reset_d;
            done_q       <= done_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign rst_fm          = rst_fm_q;
    assign write_enable_fm = we_q;
    assign write_addr_fm   = addr_q;
    assign write_data_fm   = data_q;
    assign proc_reset      = proc_reset_q;
    assign done            = done_q;
    assign words_written   = words_q;
    assign addr_wrap       = wrap_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed boot sequences plus randomized segments,
// checked against a write-list model of the command stream.
module tb_program_loader;

    localparam int unsigned PROC_RST = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, rst_fm, write_enable_fm, proc_reset, done, addr_wrap;
    logic [31:0] write_addr_fm;
    logic [15:0] write_data_fm, words_written;

    int          n_chk  = 0;
    int          n_pass = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [15:0] pend_data = '0;
    logic [31:0] m_addr = '0;
    logic [15:0] m_words = '0;
    logic        m_wrap = 1'b0;
    logic [15:0] seg[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rst_fm          (rst_fm),
        .write_enable_fm (write_enable_fm),
        .write_addr_fm   (write_addr_fm),
        .write_data_fm   (write_data_fm),
        .proc_reset      (proc_reset),
        .done            (done),
        .words_written   (words_written),
        .addr_wrap       (addr_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock; every cycle the strobe must match exactly what the model expects.
    task automatic step();
        @(posedge clk);
        #1;
        check("strobe", 32'(write_enable_fm), 32'(pend));
        check("strobe_in_fmrst", 32'(write_enable_fm & rst_fm), 0);
        if (pend) begin
            check("waddr", write_addr_fm, pend_addr);
            check("wdata", 32'(write_data_fm), 32'(pend_data));
        end
        pend = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input logic [15:0] w, input bit payload);
        bit acc;
        int waited;
        acc    = 1'b0;
        waited = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!acc && waited < 20) begin
            acc = in_ready;
            if (acc && payload) begin
                pend      = 1'b1;
                pend_addr = m_addr;
                pend_data = w;
            end
            step();
            waited++;
        end
        check("accept", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_rst_fm", 32'(rst_fm), 1);
        check("rst_proc_reset", 32'(proc_reset), 1);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_we", 32'(write_enable_fm), 0);
        check("rst_addr", write_addr_fm, 0);
        check("rst_data", 32'(write_data_fm), 0);
        check("rst_done", 32'(done), 0);
        check("rst_words", 32'(words_written), 0);
        check("rst_wrap", 32'(addr_wrap), 0);
    endtask

    task automatic release_reset();
        reset   = 1'b0;
        m_addr  = '0;
        m_words = '0;
        m_wrap  = 1'b0;
        step();
        check("fmrst_c2_rst_fm", 32'(rst_fm), 1);
        check("fmrst_c2_ready", 32'(in_ready), 0);
        step();
        check("fmrst_c3_rst_fm", 32'(rst_fm), 0);
        check("fmrst_c3_ready", 32'(in_ready), 1);
        check("fmrst_c3_proc_reset", 32'(proc_reset), 1);
        check("fmrst_c3_done", 32'(done), 0);
    endtask

    task automatic setaddr(input logic [31:0] a);
        send({2'b01, 14'($urandom)}, 1'b0);
        send(a[31:16], 1'b0);
        send(a[15:0], 1'b0);
        m_addr = a;
        check("setaddr", write_addr_fm, a);
    endtask

    // Sends a DATA header plus seg[]; the model advances one address per word.
    task automatic run_seg(input int gap_at, input int gap_len, input bit rnd_gaps);
        send({2'b10, 14'(seg.size())}, 1'b0);
        foreach (seg[i]) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step();
                    check("gap_ready", 32'(in_ready), 1);
                    check("gap_addr", write_addr_fm, m_addr);
                end
            end else if (rnd_gaps && i > 0) begin
                idle($urandom_range(0, 2));
            end
            send(seg[i], 1'b1);
            if (m_addr == 32'hFFFF_FFFF) m_wrap = 1'b1;
            m_addr = m_addr + 32'd1;
            if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
        end
        step();
        check("seg_addr", write_addr_fm, m_addr);
        check("seg_words", 32'(words_written), 32'(m_words));
        check("seg_wrap", 32'(addr_wrap), 32'(m_wrap));
        check("seg_ready", 32'(in_ready), 1);
    endtask

    initial begin
        // Power-on reset and memory-reset hold
        reset = 1'b1;
        step();
        step();
        check_reset_vals();
        release_reset();

        // Directed segment at 0x20
        setaddr(32'h0000_0020);
        seg = '{16'h4115, 16'h4AFF, 16'hCAFF};
        run_seg(-1, 0, 1'b0);
        check("t2_words", 32'(words_written), 3);

        // Three-cycle valid gap in the middle of a segment
        setaddr(32'h0001_0040);
        seg = {};
        for (int k = 0; k < 5; k++) seg.push_back(16'($urandom));
        run_seg(2, 3, 1'b0);

        // Address wrap from all-ones
        setaddr(32'hFFFF_FFFF);
        seg = '{16'h1234, 16'hABCD};
        run_seg(-1, 0, 1'b0);
        check("t5_wrap", 32'(addr_wrap), 1);
        check("t5_addr", write_addr_fm, 1);

        // NOP and zero-length DATA leave the loader idle
        send({2'b00, 14'($urandom)}, 1'b0);
        send(16'h8000, 1'b0);
        idle(2);
        check("nop_ready", 32'(in_ready), 1);
        check("nop_addr", write_addr_fm, m_addr);

        // Randomized segments, sometimes continuing from the current address
        for (int r = 0; r < 5; r++) begin
            if (r != 2) setaddr($urandom);
            seg = {};
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) seg.push_back(16'($urandom));
            run_seg(-1, 0, 1'b1);
        end

        // Reset on the cycle a payload word is accepted
        setaddr(32'h0000_0100);
        send({2'b10, 14'd5}, 1'b0);
        send(16'h5A5A, 1'b1);
        in_data  = 16'hA5A5;
        in_valid = 1'b1;
        reset    = 1'b1;
        step();
        check_reset_vals();
        in_valid = 1'b0;
        release_reset();

        // DATA without SETADDR starts at address 0
        seg = '{16'h0F0F, 16'hF0F0, 16'h3C3C};
        run_seg(-1, 0, 1'b0);
        check("noset_addr", write_addr_fm, 3);

        // ISR load at 0, then START and processor release
        setaddr(32'h0000_0000);
        seg = '{16'h615F, 16'h52DF, 16'hCC3F, 16'hB43F};
        run_seg(-1, 0, 1'b0);
        send({2'b11, 14'($urandom)}, 1'b0);
        check("rel_proc_reset", 32'(proc_reset), 1);
        check("rel_ready", 32'(in_ready), 0);
        check("rel_done", 32'(done), 0);
        for (int k = 1; k < int'(PROC_RST); k++) begin
            step();
            check("rel_hold", 32'(proc_reset), 1);
        end
        step();
        check("run_proc_reset", 32'(proc_reset), 0);
        check("run_done", 32'(done), 1);

        // RUN ignores further stream traffic
        in_data  = 16'h8003;
        in_valid = 1'b1;
        idle(4);
        in_valid = 1'b0;
        check("run_ready", 32'(in_ready), 0);
        check("run_done_hold", 32'(done), 1);
        check("run_words", 32'(words_written), 32'(m_words));
        check("run_addr", write_addr_fm, m_addr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

endmodule
